fifo_pkt: RTL and testbench

Packet-aware synchronous FIFO that generalises the plain byte FIFO used in the packet-copy datapath. Words are written with an end-of-packet marker and only become visible to the reader once the whole packet has been committed. A partially written packet can be discarded explicitly or automatically on overflow. The block adds fill level, almost-full/almost-empty thresholds and sticky error flags. It sits between the packet receiver and the copy engine.

---
 rtl/fifo_pkt_if.sv | 31 +++
 rtl/fifo_pkt.sv | 114 +++++++++++
 tb/tb_fifo_pkt.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkt_if.sv
// Write/read handshake bundle between the packet receiver, fifo_pkt and the copy engine.
`timescale 1ns/1ps
interface fifo_pkt_if #(
  parameter int pBITS  = 8,
  parameter int pWIDTH = 4
);
  logic             iwr;
  logic [pBITS-1:0] iw_data;
  logic             ieop;
  logic             idrop;
  logic             ird;
  logic             iclr_err;
  logic [pBITS-1:0] or_data;
  logic             oempty;
  logic             ofull;
  logic             oafull;
  logic             oaempty;
  logic [pWIDTH:0]  olevel;
  logic             ooverflow;
  logic             ounderflow;

  modport master (
    output iwr, iw_data, ieop, idrop, ird, iclr_err,
    input  or_data, oempty, ofull, oafull, oaempty, olevel, ooverflow, ounderflow
  );

  modport slave (
    input  iwr, iw_data, ieop, idrop, ird, iclr_err,
    output or_data, oempty, ofull, oafull, oaempty, olevel, ooverflow, ounderflow
  );
endinterface

// File: rtl/fifo_pkt.sv
// Packet-aware FIFO: words become readable only after the packet's eop word is committed;
// partial packets are discarded on idrop or on overflow.
`timescale 1ns/1ps
module fifo_pkt #(
  parameter int pBITS   = 8,
  parameter int pWIDTH  = 4,
  parameter int pAFULL  = 12,
  parameter int pAEMPTY = 2
) (
  input logic      iclk,
  input logic      ireset,
  fifo_pkt_if.slave bus
);
  localparam int              DEPTH  = 1 << pWIDTH;
  localparam logic [pWIDTH:0] FULLV  = (pWIDTH+1)'(DEPTH);
  localparam logic [pWIDTH:0] AFULLV = (pWIDTH+1)'(pAFULL);
  localparam logic [pWIDTH:0] AEMPV  = (pWIDTH+1)'(pAEMPTY);

  typedef enum logic [1:0] {IDLE, PKT, DROP} wstate_t;

  logic [pBITS-1:0] mem [0:DEPTH-1];
  wstate_t          state, stateNxt;
  logic [pWIDTH:0]  wrPtr, cmPtr, rdPtr;
  logic [pWIDTH:0]  wrPtrNxt, cmPtrNxt;
  logic [pWIDTH:0]  used, level;
  logic             full, empty;
  logic             wrEn, rdEn, ovfSet, unfSet;
  logic             ovfFlag, unfFlag;

  // Flags come from registered pointers only, never from this cycle's requests.
  assign used  = wrPtr - rdPtr;
  assign level = cmPtr - rdPtr;
  assign full  = (used == FULLV);
  assign empty = (level == '0);

  assign bus.or_data    = mem[rdPtr[pWIDTH-1:0]];
  assign bus.oempty     = empty;
  assign bus.ofull      = full;
  assign bus.oafull     = (used >= AFULLV);
  assign bus.oaempty    = (level <= AEMPV);
  assign bus.olevel     = level;
  assign bus.ooverflow  = ovfFlag;
  assign bus.ounderflow = unfFlag;

  assign rdEn   = bus.ird & ~empty;
  assign unfSet = bus.ird & empty;

  always_comb begin
    stateNxt = state;
    wrPtrNxt = wrPtr;
    cmPtrNxt = cmPtr;
    wrEn     = 1'b0;
    ovfSet   = 1'b0;
    if (bus.idrop) begin
      // Explicit discard wins over any concurrent write, which is silently ignored.
      wrPtrNxt = cmPtr;
      stateNxt = IDLE;
    end else if (bus.iwr) begin
      case (state)
        DROP: begin
          ovfSet = 1'b1;
          if (bus.ieop) stateNxt = IDLE;
        end
        default: begin
          if (full) begin
            ovfSet   = 1'b1;
            wrPtrNxt = cmPtr;
            stateNxt = bus.ieop ? IDLE : DROP;
          end else begin
            wrEn     = 1'b1;
            wrPtrNxt = wrPtr + 1'b1;
            if (bus.ieop) begin
              cmPtrNxt = wrPtr + 1'b1;
              stateNxt = IDLE;
            end else begin
              stateNxt = PKT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state <= IDLE;
      wrPtr <= '0;
      cmPtr <= '0;
      rdPtr <= '0;
    end else begin
      state <= stateNxt;
      wrPtr <= wrPtrNxt;
      cmPtr <= cmPtrNxt;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Setting an error takes priority over a same-cycle clear.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      ovfFlag <= 1'b0;
      unfFlag <= 1'b0;
    end else begin
      if (ovfSet)            ovfFlag <= 1'b1;
      else if (bus.iclr_err) ovfFlag <= 1'b0;
      if (unfSet)            unfFlag <= 1'b1;
      else if (bus.iclr_err) unfFlag <= 1'b0;
    end
  end

  always_ff @(posedge iclk) begin
    if (wrEn) mem[wrPtr[pWIDTH-1:0]] <= bus.iw_data;
  end
endmodule

// File: tb/tb_fifo_pkt.sv
// Scoreboard bench for fifo_pkt: committed words are queued on write and checked on read.
`timescale 1ns/1ps
module tb_fifo_pkt;
  logic iclk = 1'b0;
  logic ireset;
  int   nChk = 0;
  int   nPass = 0;
  logic [7:0] sb[$];

  always #5 iclk = ~iclk;

  fifo_pkt_if #(.pBITS(8), .pWIDTH(4)) bus ();
  fifo_pkt #(.pBITS(8), .pWIDTH(4), .pAFULL(12), .pAEMPTY(2)) dut (
    .iclk(iclk), .ireset(ireset), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // One clock with the given requests; a read checks or_data against the scoreboard head.
  task automatic step(input logic wr, input logic [7:0] d, input logic eop,
                      input logic drop, input logic rd, input logic clr);
    logic [7:0] e;
    bus.iwr = wr; bus.iw_data = d; bus.ieop = eop;
    bus.idrop = drop; bus.ird = rd; bus.iclr_err = clr;
    if (rd && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rdata", {24'd0, bus.or_data}, {24'd0, e});
    end
    @(posedge iclk); #1;
    bus.iwr = 0; bus.ieop = 0; bus.idrop = 0; bus.ird = 0; bus.iclr_err = 0;
  endtask

  task automatic writePkt(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1, base + 8'(i), i == n-1, 0, 0, 0);
    for (int i = 0; i < n; i++) sb.push_back(base + 8'(i));
  endtask

  task automatic chkLvl();
    chk("level",  {27'd0, bus.olevel}, sb.size());
    chk("afull",  {31'd0, bus.oafull}, {31'd0, sb.size() >= 12});
    chk("aempty", {31'd0, bus.oaempty}, {31'd0, sb.size() <= 2});
    chk("empty",  {31'd0, bus.oempty}, {31'd0, sb.size() == 0});
  endtask

  task automatic chkReset();
    chk("rstEmpty",  {31'd0, bus.oempty}, 1);
    chk("rstFull",   {31'd0, bus.ofull}, 0);
    chk("rstAfull",  {31'd0, bus.oafull}, 0);
    chk("rstAempty", {31'd0, bus.oaempty}, 1);
    chk("rstLevel",  {27'd0, bus.olevel}, 0);
    chk("rstOvf",    {31'd0, bus.ooverflow}, 0);
    chk("rstUnf",    {31'd0, bus.ounderflow}, 0);
  endtask

  initial begin
    ireset = 1;
    bus.iwr = 0; bus.iw_data = 0; bus.ieop = 0; bus.idrop = 0; bus.ird = 0; bus.iclr_err = 0;
    repeat (3) @(posedge iclk);
    #1 chkReset();
    ireset = 0;
    @(posedge iclk); #1;

    // basic 3-word packet
    step(1, 8'hA0, 0, 0, 0, 0); chk("visA0", {31'd0, bus.oempty}, 1);
    step(1, 8'hA1, 0, 0, 0, 0); chk("visA1", {31'd0, bus.oempty}, 1);
    step(1, 8'hA2, 1, 0, 0, 0);
    sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hA2);
    chk("commitLvl", {27'd0, bus.olevel}, 3);
    chk("commitEmpty", {31'd0, bus.oempty}, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    chk("drainEmpty", {31'd0, bus.oempty}, 1);

    // partial packet discarded by idrop
    for (int i = 0; i < 5; i++) step(1, 8'h50 + 8'(i), 0, 0, 0, 0);
    step(1, 8'h5F, 0, 1, 0, 0);
    chk("dropLvl", {27'd0, bus.olevel}, 0);
    writePkt(2, 8'hB0);
    chk("bLvl", {27'd0, bus.olevel}, 2);
    step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 1, 0);
    chk("dropNoOvf", {31'd0, bus.ooverflow}, 0);

    // 20-word packet overflows
    for (int i = 0; i < 16; i++) step(1, 8'h40 + 8'(i), 0, 0, 0, 0);
    chk("ovfFull", {31'd0, bus.ofull}, 1);
    chk("ovfAfull", {31'd0, bus.oafull}, 1);
    chk("ovfLvl0", {27'd0, bus.olevel}, 0);
    step(1, 8'h50, 0, 0, 0, 0);
    chk("ovfSet", {31'd0, bus.ooverflow}, 1);
    chk("ovfRewind", {31'd0, bus.ofull}, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("ovfClr", {31'd0, bus.ooverflow}, 0);
    step(1, 8'h51, 0, 0, 0, 0);
    chk("dropStateOvf", {31'd0, bus.ooverflow}, 1);
    step(1, 8'h52, 0, 0, 0, 0);
    step(1, 8'h53, 1, 0, 0, 0);
    chk("ovfLvl", {27'd0, bus.olevel}, 0);
    chk("ovfEmpty", {31'd0, bus.oempty}, 1);
    writePkt(2, 8'hC0);
    chk("postOvfLvl", {27'd0, bus.olevel}, 2);
    step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);

    // level wrap with interleaved one-word packets
    for (int i = 0; i < 13; i++) begin
      step(1, 8'h80 + 8'(i), 1, 0, 0, 0); sb.push_back(8'h80 + 8'(i)); chkLvl();
    end
    for (int i = 13; i < 40; i++) begin
      step(1, 8'h80 + 8'(i), 1, 0, 1, 0); sb.push_back(8'h80 + 8'(i)); chkLvl();
    end
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0, 0, 1, 0); chkLvl();
    end

    // underflow and clear priority
    step(0, 0, 0, 0, 1, 0);
    chk("unfSet", {31'd0, bus.ounderflow}, 1);
    chk("unfLvl", {27'd0, bus.olevel}, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("unfClr", {31'd0, bus.ounderflow}, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("unfPrio", {31'd0, bus.ounderflow}, 1);
    step(0, 0, 0, 0, 0, 1);
    writePkt(1, 8'hD7);
    chk("unfRdPtr", {27'd0, bus.olevel}, 1);
    step(0, 0, 0, 0, 1, 0);

    // full FIFO with simultaneous write+read
    writePkt(16, 8'h10);
    chk("fullF", {31'd0, bus.ofull}, 1);
    chk("fullLvl", {27'd0, bus.olevel}, 16);
    step(1, 8'hEE, 0, 0, 1, 0);
    chk("wrRdOvf", {31'd0, bus.ooverflow}, 1);
    chk("wrRdLvl", {27'd0, bus.olevel}, 15);
    step(1, 8'hEF, 1, 0, 0, 0);
    chk("dropExitLvl", {27'd0, bus.olevel}, 15);
    step(1, 8'hF0, 0, 0, 0, 0);
    chk("partFull", {31'd0, bus.ofull}, 1);

    // async reset mid-packet
    #2 ireset = 1;
    #1 chkReset();
    sb.delete();
    @(negedge iclk) ireset = 0;
    @(posedge iclk); #1;
    chk("postRstEmpty", {31'd0, bus.oempty}, 1);
    writePkt(2, 8'h60);
    chk("postRstLvl", {27'd0, bus.olevel}, 2);
    step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 1, 0);
    chk("postRstDrain", {31'd0, bus.oempty}, 1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
